// File: rtl/pwm_ctrl.sv
// PWM bank with shared prescaled timebase and boundary-synchronised shadow registers.
// Optional read path enabled by defining PWM_CTRL_READBACK_EN.
module pwm_ctrl #(
    parameter int          CHANNELS       = 4,
    parameter logic [15:0] PRESCALE_RESET = 16'd46874
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [7:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                rd_en,
    input  logic [7:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_PRE_LO = 8'h01;
    localparam logic [7:0] ADDR_PRE_HI = 8'h02;
    localparam logic [7:0] ADDR_DUTY   = 8'h10;

    logic                en_q, en_d;
    logic [7:0]          hold_q, hold_d;
    logic [15:0]         pre_shadow_q, pre_shadow_d;
    logic [15:0]         pre_active_q, pre_active_d;
    logic [15:0]         pre_cnt_q, pre_cnt_d;
    logic [7:0]          per_cnt_q, per_cnt_d;
    logic [7:0]          duty_shadow_q [CHANNELS];
    logic [7:0]          duty_shadow_d [CHANNELS];
    logic [7:0]          duty_active_q [CHANNELS];
    logic [7:0]          duty_active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                pstart_q;

    logic tick, boundary, wr_fire;

    assign tick     = en_q && (pre_cnt_q == pre_active_q);
    assign boundary = tick && (per_cnt_q == 8'hFF);
    assign wr_ready = !boundary;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        en_d          = en_q;
        hold_d        = hold_q;
        pre_shadow_d  = pre_shadow_q;
        duty_shadow_d = duty_shadow_q;
        if (wr_fire) begin
            unique case (1'b1)
                (wr_addr == ADDR_CTRL):   en_d = wr_data[0];
                (wr_addr == ADDR_PRE_LO): hold_d = wr_data;
                (wr_addr == ADDR_PRE_HI): pre_shadow_d = {wr_data, hold_q};
                default: ;
            endcase
            for (int ch = 0; ch < CHANNELS; ch++)
                if (wr_addr == ADDR_DUTY + 8'(ch)) duty_shadow_d[ch] = wr_data;
        end
    end

    always_comb begin
        pre_active_d  = pre_active_q;
        duty_active_d = duty_active_q;
        pre_cnt_d     = pre_cnt_q;
        per_cnt_d     = per_cnt_q;
        if (!en_q || boundary) begin
            pre_active_d  = pre_shadow_q;
            duty_active_d = duty_shadow_q;
        end
        if (!en_d) begin
            pre_cnt_d = '0;
            per_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            per_cnt_d = per_cnt_q + 8'd1;
        end else if (en_q) begin
            pre_cnt_d = pre_cnt_q + 16'd1;
        end
        // Built from next state so pwm_out lines up with the period_start pulse
        for (int ch = 0; ch < CHANNELS; ch++)
            pwm_d[ch] = en_d && (per_cnt_d < duty_active_d[ch]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            en_q          <= 1'b0;
            hold_q        <= '0;
            pre_shadow_q  <= PRESCALE_RESET;
            pre_active_q  <= PRESCALE_RESET;
            pre_cnt_q     <= '0;
            per_cnt_q     <= '0;
            duty_shadow_q <= '{default: '0};
            duty_active_q <= '{default: '0};
            pwm_q         <= '0;
            pstart_q      <= 1'b0;
        end else begin
            en_q          <= en_d;
            hold_q        <= hold_d;
            pre_shadow_q  <= pre_shadow_d;
            pre_active_q  <= pre_active_d;
            pre_cnt_q     <= pre_cnt_d;
            per_cnt_q     <= per_cnt_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
            pstart_q      <= boundary;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;

`ifdef PWM_CTRL_READBACK_EN
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q;

    always_comb begin
        rd_data_d = '0;
        unique case (1'b1)
            (rd_addr == ADDR_CTRL):   rd_data_d = {7'd0, en_q};
            (rd_addr == ADDR_PRE_LO): rd_data_d = pre_shadow_q[7:0];
            (rd_addr == ADDR_PRE_HI): rd_data_d = pre_shadow_q[15:8];
            default: ;
        endcase
        for (int ch = 0; ch < CHANNELS; ch++)
            if (rd_addr == ADDR_DUTY + 8'(ch)) rd_data_d = duty_shadow_q[ch];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_en, rd_addr};
    assign rd_data   = '0;
    assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ctrl.sv
// Scoreboard bench for pwm_ctrl: period-level reference model feeding queues,
// monitor checks period_start, per-period high time, wr_ready and reads.
module tb_pwm_ctrl;

    localparam int CH = 4;
    localparam logic [15:0] PRE_RST = 16'd46874;
`ifdef PWM_CTRL_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [7:0]    wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_addr = '0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    pwm_ctrl #(.CHANNELS(CH), .PRESCALE_RESET(PRE_RST)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [31:0]      len;
        logic [7:0][15:0] hi;
    } prec_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic        valid;
        logic [7:0]  data;
    } rdrec_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic        rdy;
    } rdyrec_t;

    prec_t   pq[$];
    rdrec_t  dq[$];
    rdyrec_t rq[$];

    int n_chk = 0;
    int n_fail = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole periods of 256*(prescale+1) clocks
    int unsigned m_cyc = 0;
    int unsigned m_pos = 0;
    bit          m_en = 1'b0;
    logic [7:0]  m_hold = '0;
    logic [15:0] m_pre_s = PRE_RST;
    logic [15:0] m_pre_a = PRE_RST;
    logic [7:0]  m_ds [8] = '{default: '0};
    logic [7:0]  m_da [8] = '{default: '0};

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (a == 8'h00) return {7'd0, m_en};
        if (a == 8'h01) return m_pre_s[7:0];
        if (a == 8'h02) return m_pre_s[15:8];
        if (a >= 8'h10 && a < 8'h10 + 8'(CH)) return m_ds[a - 8'h10];
        return 8'h00;
    endfunction

    always @(negedge clk_in) begin
        int unsigned len;
        bit bnd, acc;
        prec_t p;
        rdrec_t d;
        rdyrec_t r;
        if (run) begin
            len = 256 * (int'(m_pre_a) + 1);
            bnd = m_en && (m_pos == len - 1);
            acc = wr_valid && !bnd;
            if (rd_en) begin
                d.cyc = m_cyc + 1;
                d.valid = READBACK;
                d.data = READBACK ? model_rd(rd_addr) : 8'h00;
                dq.push_back(d);
            end
            if (bnd) begin
                p.cyc = m_cyc + 1;
                p.len = len;
                for (int c = 0; c < 8; c++)
                    p.hi[c] = 16'(int'(m_da[c]) * (int'(m_pre_a) + 1));
                pq.push_back(p);
                m_pos = 0;
                m_da = m_ds;
                m_pre_a = m_pre_s;
            end else if (m_en) begin
                m_pos++;
            end
            if (!m_en) begin
                m_da = m_ds;
                m_pre_a = m_pre_s;
            end
            if (acc) begin
                if (wr_addr == 8'h00) begin
                    m_en = wr_data[0];
                    if (!m_en) m_pos = 0;
                end else if (wr_addr == 8'h01) begin
                    m_hold = wr_data;
                end else if (wr_addr == 8'h02) begin
                    m_pre_s = {wr_data, m_hold};
                end else if (wr_addr >= 8'h10 && wr_addr < 8'h10 + 8'(CH)) begin
                    m_ds[wr_addr - 8'h10] = wr_data;
                end
            end
            len = 256 * (int'(m_pre_a) + 1);
            r.cyc = m_cyc + 1;
            r.rdy = !(m_en && (m_pos == len - 1));
            rq.push_back(r);
            m_cyc++;
        end
    end

    // Monitor
    int unsigned mon_cyc = 0;
    logic [7:0]  hist [1024];

    always @(negedge clk_in) begin
        logic [7:0] pw8;
        prec_t p;
        rdrec_t d;
        rdyrec_t r;
        int cnt;
        if (run) begin
            pw8 = '0;
            pw8[CH-1:0] = pwm_out;
            hist[mon_cyc % 1024] = pw8;
            if (rq.size() > 0 && rq[0].cyc == mon_cyc) begin
                r = rq.pop_front();
                if (!r.rdy || wr_valid) chk("wr_ready", int'(wr_ready), int'(r.rdy));
            end
            if (dq.size() > 0 && dq[0].cyc == mon_cyc) begin
                d = dq.pop_front();
                chk("rd_valid", int'(rd_valid), int'(d.valid));
                chk("rd_data", int'(rd_data), int'(d.data));
            end else if (rd_valid) begin
                chk("rd_valid_spurious", int'(rd_valid), 0);
            end
            if (pq.size() > 0 && pq[0].cyc == mon_cyc) begin
                p = pq.pop_front();
                chk("period_start", int'(period_start), 1);
                for (int c = 0; c < CH; c++) begin
                    cnt = 0;
                    for (int k = 1; k <= int'(p.len); k++)
                        cnt += int'(hist[(mon_cyc - k) % 1024][c]);
                    chk($sformatf("high_time_ch%0d", c), cnt, int'(p.hi[c]));
                end
            end else if (period_start) begin
                chk("period_start_spurious", int'(period_start), 0);
            end
            mon_cyc++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d,
                      input bit with_rd, output int stalls);
        logic rdy;
        wr_addr = a;
        wr_data = d;
        wr_valid = 1'b1;
        rd_en = with_rd;
        rd_addr = a;
        stalls = 0;
        forever begin
            @(negedge clk_in);
            rdy = wr_ready;
            @(posedge clk_in);
            #1;
            rd_en = 1'b0;
            if (rdy) break;
            stalls++;
            if (stalls > 2000) begin
                chk("wr_timeout", stalls, 0);
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        rd_en = 1'b1;
        rd_addr = a;
        @(posedge clk_in);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic wait_pstart();
        int n;
        n = 0;
        forever begin
            @(negedge clk_in);
            if (period_start) break;
            n++;
            if (n > 2000) begin
                n_chk++;
                n_fail++;
                $display("FAIL period_start_timeout: no pulse in %0d cycles", n);
                break;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    logic [7:0] raddrs [8] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20};

    initial begin
        int st;
        int op;
        logic [7:0] a;

        #23;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_wr_ready", int'(wr_ready), 1);
        chk("reset_period_start", int'(period_start), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        run = 1'b1;

        rd(8'h01);
        rd(8'h02);
        rd(8'h00);
        rd(8'h10);
        idle(2);

        wr(8'h01, 8'h00, 1'b0, st);
        wr(8'h02, 8'h00, 1'b0, st);
        wr(8'h10, 8'd64, 1'b0, st);
        wr(8'h13, 8'd255, 1'b0, st);
        wr(8'h00, 8'h01, 1'b0, st);
        idle(800);

        wait_pstart();
        idle(100);
        wr(8'h10, 8'd192, 1'b1, st);
        idle(600);

        wait_pstart();
        idle(254);
        wr(8'h11, 8'd100, 1'b0, st);
        chk("held_write_stall_cycles", st, 1);
        idle(600);

        wr(8'h01, 8'h01, 1'b0, st);
        idle(600);
        rd(8'h01);
        wr(8'h02, 8'h00, 1'b0, st);
        idle(1300);

        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: wr(8'h10 + 8'($urandom_range(0, CH - 1)),
                         8'($urandom_range(0, 255)), 1'b0, st);
                2: begin
                    wr(8'h01, 8'($urandom_range(0, 2)), 1'b0, st);
                    wr(8'h02, 8'h00, 1'b0, st);
                end
                3: begin
                    a = raddrs[$urandom_range(0, 7)];
                    if (a == 8'h00 || a == 8'h02) a = 8'h12;
                    wr(a, 8'($urandom_range(0, 255)), 1'b1, st);
                end
                4: wr(8'h14 + 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0, st);
                default: begin
                    wr(8'h00, 8'h00, 1'b0, st);
                    chk("pwm_after_disable", int'(pwm_out), 0);
                    idle(int'($urandom_range(1, 20)));
                    wr(8'h00, 8'h01, 1'b0, st);
                end
            endcase
            rd(raddrs[$urandom_range(0, 7)]);
            idle(int'($urandom_range(0, 300)));
        end

        idle(1100);
        wr(8'h00, 8'h00, 1'b0, st);
        chk("pwm_after_final_disable", int'(pwm_out), 0);
        idle(3);
        chk("period_queue_drained", pq.size(), 0);
        chk("read_queue_drained", dq.size(), 0);

        wr(8'h10, 8'd255, 1'b0, st);
        wr(8'h00, 8'h01, 1'b0, st);
        idle(10);
        chk("pwm_high_before_reset", int'(pwm_out[0]), 1);
        run = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_reset_pwm", int'(pwm_out), 0);
        chk("async_reset_period_start", int'(period_start), 0);
        chk("async_reset_wr_ready", int'(wr_ready), 1);
        chk("async_reset_rd_valid", int'(rd_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
